// File: rtl/wb_dsp_equation_arbiter.sv
// wb_dsp_equation_arbiter
//   Shares one Wishbone master bus among NUM_EQ equation engines.
//   Arbitration is fixed priority (ARB_MODE=0, lowest index wins) or round
//   robin (ARB_MODE=1). The grant is registered, so a grant becomes visible one
//   cycle after the request. A transfer that gets no slave response for TIMEOUT
//   strobed cycles is aborted: the owner gets one error pulse and the bus is
//   parked until the owner drops cyc. TIMEOUT=0 disables the abort.
//   The block also keeps sticky per-engine done bits and a registered OR of
//   the engine done pulses.
//
// Ports
//   wb_clk, wb_rst_n            clock, asynchronous active-low reset
//   eq_*_i                      packed per-engine master signals (slice k = engine k)
//   eq_ack_o/err_o/rty_o        responses routed to the granted engine only
//   wb_*_o                      shared master bus, zero unless a transfer is active
//   wb_ack_i/err_i/rty_i        slave responses
//   eq_done_i, done_clear       per-engine done pulses, sticky-status clear
//   equation_done, done_status  registered OR of done pulses, sticky done bits
//   grant_o                     one-hot owner, zero when idle
//   timeout_flag                sticky, set when a transfer is aborted
//
// state | meaning
// IDLE  | no owner; arbitrate among engines asserting cyc
// BUSY  | owner's signals drive the bus; watch for response or timeout
// ABORT | timed out; bus parked at zero, grant held until owner drops cyc

module wb_dsp_equation_arbiter #(
  parameter int aw       = 32,
  parameter int dw       = 32,
  parameter int NUM_EQ   = 4,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [NUM_EQ*aw-1:0] eq_adr_i,
  input  logic [NUM_EQ*dw-1:0] eq_dat_i,
  input  logic [NUM_EQ*4-1:0]  eq_sel_i,
  input  logic [NUM_EQ-1:0]    eq_we_i,
  input  logic [NUM_EQ-1:0]    eq_cyc_i,
  input  logic [NUM_EQ-1:0]    eq_stb_i,
  input  logic [NUM_EQ*3-1:0]  eq_cti_i,
  input  logic [NUM_EQ*2-1:0]  eq_bte_i,
  input  logic [NUM_EQ-1:0]    eq_done_i,
  output logic [NUM_EQ-1:0]    eq_ack_o,
  output logic [NUM_EQ-1:0]    eq_err_o,
  output logic [NUM_EQ-1:0]    eq_rty_o,
  output logic [aw-1:0]        wb_adr_o,
  output logic [dw-1:0]        wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  input  logic                 done_clear,
  output logic                 equation_done,
  output logic [NUM_EQ-1:0]    done_status,
  output logic [NUM_EQ-1:0]    grant_o,
  output logic                 timeout_flag
);

  localparam int IW = (NUM_EQ > 1) ? $clog2(NUM_EQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value at which one more silent strobe cycle triggers the abort.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e            state_q;
  logic [NUM_EQ-1:0] grant_q;
  logic [IW-1:0]     last_grant_q;
  logic [CW-1:0]     cnt_q;
  logic              timeout_q;
  logic              abort_err_q;
  logic              rst_done_q;
  logic              eq_done_q;
  logic [NUM_EQ-1:0] done_q;

  int                start_d;
  logic [NUM_EQ-1:0] rot_d;
  logic              win_found_d;
  logic [IW-1:0]     win_idx_d;
  logic [NUM_EQ-1:0] grant_d;

  logic [aw-1:0] adr_m;
  logic [dw-1:0] dat_m;
  logic [3:0]    sel_m;
  logic          we_m, cyc_m, stb_m;
  logic [2:0]    cti_m;
  logic [1:0]    bte_m;
  logic          busy;
  logic          resp;

  // Rotate the request vector so bit 0 is the first candidate in search order;
  // the first set bit after rotation is the winner.
  always_comb begin
    start_d     = (ARB_MODE == 1) ? ((int'(last_grant_q) + 1) % NUM_EQ) : 0;
    rot_d       = NUM_EQ'({eq_cyc_i, eq_cyc_i} >> start_d);
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int i = 0; i < NUM_EQ; i++) begin
      if (!win_found_d && rot_d[i]) begin
        win_found_d = 1'b1;
        win_idx_d   = IW'((start_d + i) % NUM_EQ);
      end
    end
    grant_d = NUM_EQ'(1) << win_idx_d;
  end

  // Owner's slice, selected by the one-hot grant regardless of state so the
  // owner's cyc is visible in ABORT as well.
  always_comb begin
    adr_m = '0;
    dat_m = '0;
    sel_m = '0;
    we_m  = 1'b0;
    cyc_m = 1'b0;
    stb_m = 1'b0;
    cti_m = '0;
    bte_m = '0;
    for (int k = 0; k < NUM_EQ; k++) begin
      if (grant_q[k]) begin
        adr_m = adr_m | eq_adr_i[k*aw +: aw];
        dat_m = dat_m | eq_dat_i[k*dw +: dw];
        sel_m = sel_m | eq_sel_i[k*4 +: 4];
        we_m  = we_m  | eq_we_i[k];
        cyc_m = cyc_m | eq_cyc_i[k];
        stb_m = stb_m | eq_stb_i[k];
        cti_m = cti_m | eq_cti_i[k*3 +: 3];
        bte_m = bte_m | eq_bte_i[k*2 +: 2];
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign resp = wb_ack_i | wb_err_i | wb_rty_i;

  assign wb_adr_o = busy ? adr_m : '0;
  assign wb_dat_o = busy ? dat_m : '0;
  assign wb_sel_o = busy ? sel_m : '0;
  assign wb_we_o  = busy & we_m;
  assign wb_cyc_o = busy & cyc_m;
  assign wb_stb_o = busy & stb_m;
  assign wb_cti_o = busy ? cti_m : '0;
  assign wb_bte_o = busy ? bte_m : '0;

  assign eq_ack_o = busy ? (grant_q & {NUM_EQ{wb_ack_i}}) : '0;
  assign eq_rty_o = busy ? (grant_q & {NUM_EQ{wb_rty_i}}) : '0;
  // The abort error pulse is registered and lands in the first ABORT cycle.
  assign eq_err_o = busy        ? (grant_q & {NUM_EQ{wb_err_i}}) :
                    abort_err_q ? grant_q : '0;

  assign grant_o       = grant_q;
  assign timeout_flag  = timeout_q;
  assign done_status   = done_q;
  assign equation_done = eq_done_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_EQ - 1);
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      abort_err_q  <= 1'b0;
      rst_done_q   <= 1'b0;
      eq_done_q    <= 1'b0;
      done_q       <= '0;
    end else begin
      // rst_done_q holds off arbitration for the first edge after reset.
      rst_done_q  <= 1'b1;
      abort_err_q <= 1'b0;
      eq_done_q   <= |eq_done_i;
      done_q      <= (done_q & ~{NUM_EQ{done_clear}}) | eq_done_i;
      case (state_q)
        IDLE: begin
          if (rst_done_q && win_found_d) begin
            grant_q      <= grant_d;
            last_grant_q <= win_idx_d;
            cnt_q        <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (!cyc_m) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (resp) begin
            cnt_q <= '0;
          end else if (stb_m) begin
            if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
              state_q     <= ABORT;
              abort_err_q <= 1'b1;
              timeout_q   <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ABORT: begin
          if (!cyc_m) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_dsp_equation_arbiter.md
WB_DSP_EQUATION_ARBITER -- requirements
Module: wb_dsp_equation_arbiter

Interface
REQ-001 SHALL have parameter aw, default 32, address width.
REQ-002 SHALL have parameter dw, default 32, data width.
REQ-003 SHALL have parameter NUM_EQ, default 4, number of equation engines; legal range 1..8.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority, lowest index wins; 1 = round robin.
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles without ack/err/rty before abort; 0 disables the timeout.
REQ-006 SHALL have ports, one per line (name, direction, width, meaning):
- wb_clk  in  1  single clock; all state on rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- eq_adr_i  in  NUM_EQ*aw  packed engine addresses; engine k occupies slice k.
- eq_dat_i  in  NUM_EQ*dw  packed engine write data.
- eq_sel_i  in  NUM_EQ*4  packed byte selects.
- eq_we_i / eq_cyc_i / eq_stb_i  in  NUM_EQ each  per-engine strobes.
- eq_cti_i  in  NUM_EQ*3  packed cycle type.
- eq_bte_i  in  NUM_EQ*2  packed burst type.
- eq_done_i  in  NUM_EQ  per-engine done pulses.
- eq_ack_o / eq_err_o / eq_rty_o  out  NUM_EQ each  routed responses.
- wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o  out  aw, dw, 4, 1, 1, 1, 3, 2  shared master bus.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave responses.
- done_clear  in  1  pulse; clears done_status.
- equation_done  out  1  registered OR of eq_done_i.
- done_status  out  NUM_EQ  sticky per-engine done bits.
- grant_o  out  NUM_EQ  one-hot current owner; all-zero when idle.
- timeout_flag  out  1  sticky; set on abort.

Function
REQ-007 FSM states SHALL be IDLE, BUSY, ABORT.
REQ-008 In IDLE with any eq_cyc_i high: SHALL pick a winner per ARB_MODE, register a one-hot grant, and enter BUSY on the next edge (1-cycle grant latency).
REQ-009 Round robin SHALL search upward from last_grant+1, modulo NUM_EQ; last_grant SHALL update on each grant.
REQ-010 In BUSY, all wb_*_o SHALL combinationally equal the granted engine's slice, including cti/bte passthrough.
REQ-011 In IDLE and ABORT, all wb_*_o SHALL be 0.
REQ-012 wb_ack_i/err_i/rty_i SHALL route only to the granted bit of eq_ack_o/err_o/rty_o; other bits SHALL be 0.
REQ-013 BUSY to IDLE SHALL occur on the edge where the granted eq_cyc_i is low; the next grant follows at least one IDLE cycle later.
REQ-014 Requests from non-granted engines during BUSY SHALL be ignored; grant SHALL NOT change mid-cycle.
REQ-015 Timeout counter behaviour:
- clears on grant and on any ack/err/rty;
- increments each BUSY cycle with wb_stb_o high and no response.
REQ-016 When the counter reaches TIMEOUT (TIMEOUT>0), the arbiter SHALL:
- drive eq_err_o[granted] high for exactly one cycle;
- set timeout_flag;
- enter ABORT.
REQ-017 ABORT SHALL hold the grant, with bus outputs 0, until the granted eq_cyc_i is low, then go to IDLE.
REQ-018 equation_done SHALL equal the OR of eq_done_i, registered one cycle late.
REQ-019 done_status[k] SHALL set on eq_done_i[k] and clear on done_clear; set SHALL win when both occur in the same cycle.
REQ-020 With NUM_EQ=1, the arbiter SHALL still insert the 1-cycle grant latency.

Reset
REQ-021 wb_rst_n low SHALL asynchronously force the following, regardless of any transfer in flight:
- FSM to IDLE;
- grant_o, done_status, timeout_flag, equation_done and the counter to 0;
- last_grant to NUM_EQ-1, so engine 0 wins first;
- all wb_*_o and eq_*_o to 0.
REQ-022 After wb_rst_n rises, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-023 Single request: eq_cyc_i=0010, eq_stb_i=0010, ack after 2 cycles -> grant_o=0010 one cycle later; wb_adr_o = slice 1; eq_ack_o=0010 for one cycle.
REQ-024 Round robin: all four engines request continuously, each holding cyc 3 cycles -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-025 Fixed priority (ARB_MODE=0): engines 1 and 3 request together -> engine 1 granted first, engine 3 after engine 1 drops cyc.
REQ-026 Timeout (TIMEOUT=4): slave never acks -> after 4 stb cycles, eq_err_o[granted]=1 for one cycle, timeout_flag=1, wb_cyc_o=0 until the engine drops cyc.
REQ-027 Reset mid-BUSY, then done plus clear: wb_rst_n low during BUSY -> all outputs 0 in the same cycle. Afterwards, eq_done_i=0100 together with done_clear -> done_status=0100 and equation_done=1 one cycle later.
